// File: rtl/sound_pkg.sv
// Shared types and the note half-period table for the tone player.
package sound_pkg;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} tone_state_t;

  localparam int NUM_TONES = 10;

  // Half-periods in 50 MHz clocks for C4, D4, E4, F4, G4, A4, B4, C5, D5, E5
  localparam logic [16:0] HP_TABLE [NUM_TONES] = '{
    17'd95556, 17'd85131, 17'd75843, 17'd71586, 17'd63776,
    17'd56818, 17'd50619, 17'd47778, 17'd42566, 17'd37922
  };

  // Scaled half-period; never returns 0 so the divider always has a legal reload
  function automatic logic [16:0] half_period_of(input logic [3:0] idx, input int shift);
    logic [16:0] v;
    v = (idx < 4'(NUM_TONES)) ? (HP_TABLE[idx] >> shift) : 17'd1;
    if (v == 17'd0) v = 17'd1;
    return v;
  endfunction

endpackage

// File: rtl/tone_divider.sv
// Reloadable half-period down-counter driving a toggle flop; the square bit
// is cleared whenever the divider is neither loading nor running.
module tone_divider
  import sound_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        run,
  input  logic [16:0] half_period,
  output logic        sq
);

  logic [16:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 17'd0;
      sq    <= 1'b0;
    end else if (load) begin
      count <= half_period - 17'd1;
      sq    <= 1'b1;
    end else if (run) begin
      if (count == 17'd0) begin
        count <= half_period - 17'd1;
        sq    <= ~sq;
      end else begin
        count <= count - 17'd1;
      end
    end else begin
      sq <= 1'b0;
    end
  end

endmodule

// File: rtl/sound_tone_player.sv
// Plays a tone index as a square wave for a fixed note time, then a silent
// gap, pulsing tone_done when the note and gap complete uninterrupted.
module sound_tone_player
  import sound_pkg::*;
#(
  parameter int NOTE_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 1_250_000,
  parameter int HP_SHIFT    = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] tone,
  input  logic       tone_valid,
  input  logic       mute,
  output logic       audio_out,
  output logic       busy,
  output logic       tone_done,
  output logic [3:0] cur_tone
);

  localparam logic [23:0] NOTE_LOAD = 24'(NOTE_CYCLES - 1);
  localparam logic [23:0] GAP_LOAD  = 24'(GAP_CYCLES - 1);

  tone_state_t state;
  logic [23:0] dur;
  logic        accept;
  logic        play_run;
  logic        sq;
  logic [16:0] half_period;

  assign accept      = enable && tone_valid && (tone <= 4'd9);
  // Stop the divider on the last PLAY cycle so the square bit is cleared entering GAP
  assign play_run    = enable && (state == PLAY) && (dur != 24'd0);
  assign half_period = half_period_of(accept ? tone : cur_tone, HP_SHIFT);

  tone_divider u_divider (
    .clk         (clk),
    .reset       (reset),
    .load        (accept),
    .run         (play_run),
    .half_period (half_period),
    .sq          (sq)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      dur       <= 24'd0;
      cur_tone  <= 4'd0;
      tone_done <= 1'b0;
    end else begin
      tone_done <= 1'b0;
      if (!enable) begin
        state <= IDLE;
        dur   <= 24'd0;
      end else if (accept) begin
        // A strobe in the final GAP cycle still completes the previous note
        tone_done <= (state == GAP) && (dur == 24'd0);
        state     <= PLAY;
        cur_tone  <= tone;
        dur       <= NOTE_LOAD;
      end else begin
        case (state)
          PLAY: begin
            if (dur == 24'd0) begin
              state <= GAP;
              dur   <= GAP_LOAD;
            end else begin
              dur <= dur - 24'd1;
            end
          end
          GAP: begin
            if (dur == 24'd0) begin
              state     <= IDLE;
              tone_done <= 1'b1;
            end else begin
              dur <= dur - 24'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy      = (state != IDLE);
  assign audio_out = sq & ~mute & (state == PLAY);

endmodule

// File: tb/tb_sound_tone_player.sv
// Scoreboard bench for sound_tone_player with shortened note/gap/half-periods.
module tb_sound_tone_player;

  localparam int NOTE = 20;
  localparam int GAPC = 4;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [3:0] tone;
  logic       tone_valid;
  logic       mute;
  logic       audio_out;
  logic       busy;
  logic       tone_done;
  logic [3:0] cur_tone;

  typedef struct packed {
    logic       busy;
    logic       audio;
    logic       done;
    logic [3:0] cur;
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  sound_tone_player #(
    .NOTE_CYCLES (NOTE),
    .GAP_CYCLES  (GAPC),
    .HP_SHIFT    (12)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .tone       (tone),
    .tone_valid (tone_valid),
    .mute       (mute),
    .audio_out  (audio_out),
    .busy       (busy),
    .tone_done  (tone_done),
    .cur_tone   (cur_tone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  // Output sampled 1 time unit after each rising edge against the queued expectation
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("busy",      {3'b0, busy},      {3'b0, e.busy});
      chk("audio_out", {3'b0, audio_out}, {3'b0, e.audio});
      chk("tone_done", {3'b0, tone_done}, {3'b0, e.done});
      chk("cur_tone",  cur_tone,          e.cur);
    end
  end

  // Queue the expected outputs after the next edge, then advance past that edge
  task automatic tick(input logic b, input logic a, input logic d, input logic [3:0] c);
    exp_q.push_back('{busy: b, audio: a, done: d, cur: c});
    @(posedge clk);
    #2;
  endtask

  // k counts clocks after the acceptance edge of an uninterrupted note
  task automatic expect_note(input int t, input int hp, input bit muted,
                             input int from_k, input int to_k);
    for (int k = from_k; k <= to_k; k++) begin
      tick(k < NOTE + GAPC,
           !muted && (k < NOTE) && (((k / hp) % 2) == 0),
           k == NOTE + GAPC,
           4'(t));
      tone_valid = 1'b0;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    enable      = 1'b1;
    tone        = 4'd0;
    tone_valid  = 1'b0;
    mute        = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy",  {3'b0, busy},      4'd0);
    chk("rst_audio", {3'b0, audio_out}, 4'd0);
    chk("rst_done",  {3'b0, tone_done}, 4'd0);
    chk("rst_cur",   cur_tone,          4'd0);
    reset = 1'b0;
    tick(0, 0, 0, 0);

    // Reset mid-PLAY clears outputs at once and no completion follows
    tone = 4'd5; tone_valid = 1'b1;
    expect_note(5, 13, 0, 0, 5);
    reset = 1'b1;
    #1;
    chk("async_busy",  {3'b0, busy},      4'd0);
    chk("async_audio", {3'b0, audio_out}, 4'd0);
    chk("async_done",  {3'b0, tone_done}, 4'd0);
    chk("async_cur",   cur_tone,          4'd0);
    tick(0, 0, 0, 0);
    reset = 1'b0;
    repeat (3) tick(0, 0, 0, 0);

    // Single tone 5 note from IDLE
    tone = 4'd5; tone_valid = 1'b1;
    expect_note(5, 13, 0, 0, 26);

    // Invalid tones are ignored in IDLE
    tone = 4'd12; tone_valid = 1'b1;
    tick(0, 0, 0, 5);
    tone = 4'd15;
    tick(0, 0, 0, 5);
    tone_valid = 1'b0;
    tick(0, 0, 0, 5);

    // Tone 0, invalid strobe ignored mid-PLAY, then retrigger with tone 9 at clock 10
    tone = 4'd0; tone_valid = 1'b1;
    expect_note(0, 23, 0, 0, 4);
    tone = 4'd13; tone_valid = 1'b1;
    expect_note(0, 23, 0, 5, 9);
    tone = 4'd9; tone_valid = 1'b1;
    expect_note(9, 9, 0, 0, 26);

    // Muted tone 9: timing unchanged, audio silent
    mute = 1'b1;
    tone = 4'd9; tone_valid = 1'b1;
    expect_note(9, 9, 1, 0, 25);
    mute = 1'b0;

    // Chain tone 3 in the final GAP cycle of tone 9, then drop enable mid-PLAY
    tone = 4'd9; tone_valid = 1'b1;
    expect_note(9, 9, 0, 0, 23);
    tone = 4'd3; tone_valid = 1'b1;
    tick(1, 1, 1, 3);
    tone_valid = 1'b0;
    expect_note(3, 17, 0, 1, 7);
    enable = 1'b0;
    tick(0, 0, 0, 3);
    tone = 4'd7; tone_valid = 1'b1;
    tick(0, 0, 0, 3);
    tone_valid = 1'b0;
    tick(0, 0, 0, 3);
    enable = 1'b1;
    repeat (3) tick(0, 0, 0, 3);

    @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sound_tone_player.md
# sound_tone_player

Converts the 4-bit tone index produced by the sound-sequencing counter into an audible square wave on a single speaker pin. On each accepted tone strobe it plays the note for a fixed duration, then holds a silent inter-note gap, and reports completion. It sits directly downstream of the tone counter: `tone` and `tc` feed this block, and `audio_out` drives the board audio/buzzer output.

## Interface
Parameters:
- `NOTE_CYCLES`, default 12_500_000: length of the PLAY phase in clocks (250 ms at 50 MHz).
- `GAP_CYCLES`, default 1_250_000: length of the silent GAP phase in clocks.
- `HP_SHIFT`, default 0: right shift applied to every half-period table entry. Used to shorten simulation.

Ports:
- `clk` in 1: system clock, 50 MHz.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: block enable. When low, the block is forced to IDLE.
- `tone` in 4: note index. 0..9 are valid; 10..15 are invalid.
- `tone_valid` in 1: single-cycle strobe requesting playback of `tone`. Normally connected to the counter's `tc`.
- `mute` in 1: silences `audio_out` without disturbing any timing.
- `audio_out` out 1: square-wave speaker drive.
- `busy` out 1: high whenever the state is not IDLE.
- `tone_done` out 1: one-cycle pulse when a note plus its gap completes.
- `cur_tone` out 4: latched index of the note being played.

## Operation
- FSM states: IDLE, PLAY, GAP.
- IDLE → PLAY when `enable && tone_valid && tone<=9`.
  - On this transition: latch `tone` into `cur_tone`; load the half-period counter with `HP[tone]-1` and the duration counter with `NOTE_CYCLES-1`; set the square bit to 1.
- PLAY behaviour:
  - The half-period counter decrements each clock.
  - When it reaches 0, the square bit toggles and the counter reloads `HP[cur_tone]-1`.
  - When the duration counter reaches 0 → GAP: load `GAP_CYCLES-1` and clear the square bit.
- GAP → IDLE when the gap counter reaches 0. `tone_done` is pulsed in the same clock edge that enters IDLE.
- Retrigger: a valid `tone_valid` in PLAY or GAP restarts PLAY with the new tone, exactly like the IDLE acceptance. No `tone_done` is issued for the aborted note.
- Simultaneous events:
  - Valid strobe in the final GAP cycle: go straight to PLAY, still pulse `tone_done`.
  - Valid strobe in the final PLAY cycle: the retrigger wins over the move to GAP.
- Invalid tone (`tone>9`): the strobe is ignored in every state. State, counters and `cur_tone` are unchanged.
- `enable` low: next state is IDLE, the square bit is cleared, and no `tone_done` is issued.
- `audio_out = square_bit & ~mute & (state==PLAY)`. This is a registered square bit gated combinationally.
- `HP[i] = HP_TABLE[i] >> HP_SHIFT`. If the shifted value is 0 it is clamped to 1.
- Widths: half-period counter 17 bits; duration/gap counter 24 bits (must hold `max(NOTE_CYCLES, GAP_CYCLES)-1`).

## Timing
- Reset values: state IDLE, `audio_out` 0, `busy` 0, `tone_done` 0, `cur_tone` 0, all counters 0.
- Latency: strobe sampled at edge N. Then `busy`=1, `audio_out`=1 (if unmuted) and `cur_tone` valid from edge N onward.
- Square wave period is 2·HP clocks. The first toggle to 0 occurs HP clocks after acceptance.
- PLAY lasts exactly `NOTE_CYCLES` clocks and GAP exactly `GAP_CYCLES` clocks. `busy` is therefore high for `NOTE_CYCLES+GAP_CYCLES` clocks per uninterrupted note.
- `tone_done`:
  - high for exactly one clock, registered;
  - coincident with the first IDLE cycle, or with the first PLAY cycle of a chained note.
- `reset` asserted mid-note: all outputs reach their reset values immediately (asynchronously). Playback resumes only on a new strobe after deassertion.

## Structure
- Package `sound_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, PLAY, GAP} tone_state_t`;
  - `localparam int NUM_TONES = 10`;
  - `localparam logic [16:0] HP_TABLE[10]` = {95556, 85131, 75843, 71586, 63776, 56818, 50619, 47778, 42566, 37922} (C4..E5 at 50 MHz).
- One natural sub-module, `tone_divider`: a reloadable half-period down-counter plus toggle flop, with ports `clk`, `reset`, `load`, `run`, `half_period`, `sq`. The FSM and duration counter stay in the top module.

## Test plan
Bench parameters: `NOTE_CYCLES=20`, `GAP_CYCLES=4`, `HP_SHIFT=12` (so HP[0]=23, HP[5]=13, HP[9]=9).
- Reset mid-PLAY with tone 5 → all outputs 0 in the same cycle; IDLE after release; no `tone_done`.
- Strobe `tone=5` once from IDLE →
  - `audio_out` 1 for 13 clocks, then 0 for 7 clocks (PLAY ends at 20);
  - `busy` high for 24 clocks;
  - single `tone_done` at clock 24;
  - `cur_tone=5`.
- Strobe `tone=12`, then `tone=15` → no state change, `busy` stays 0, `cur_tone` unchanged.
- Strobe tone 0, then a tone 9 strobe at PLAY clock 10 → restart with HP=9 and a fresh 20-clock PLAY; exactly one `tone_done` in total.
- Tone 9 with `mute=1` throughout → `audio_out` stays 0; `busy` and `tone_done` timing identical to the unmuted case.
- Strobe tone 3 in the last GAP cycle of a tone 9 note → `tone_done` pulse and PLAY entry on the same edge, `cur_tone=3`. Then drop `enable` mid-PLAY → IDLE on the next edge, no `tone_done`.
